// File: rtl/ext_loader_pkg.sv
// ext_loader_pkg: shared op encoding, FSM states and default memory depths
// for the external memory loader.
package ext_loader_pkg;

   localparam int IMEM_DEPTH_DEF = 512;
   localparam int DMEM_DEPTH_DEF = 1024;

   typedef enum logic [1:0] {
      OP_LOAD_IMEM = 2'd0,
      OP_LOAD_DMEM = 2'd1,
      OP_RUN       = 2'd2,
      OP_DUMP_DMEM = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DUMP_RD,
      ST_DUMP_WAIT,
      ST_DUMP_OUT,
      ST_FINISH
   } state_t;

   function automatic logic [31:0] word_addr(input logic [15:0] idx);
      return {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/ext_loader_out_reg.sv
// ext_loader_out_reg: single-entry valid/ready holding register for the
// dump stream; data stays stable until the consumer takes it.
module ext_loader_out_reg
   import ext_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic [31:0] i_data,
   input  logic        i_ready,
   output logic        o_valid,
   output logic [31:0] o_data
);

   logic        r_valid;
   logic [31:0] r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/ext_mem_loader.sv
// ext_mem_loader: loads IMEM/DMEM from a stream, gates the CPU for N cycles,
// and (with LOADER_DUMP_EN defined) streams DMEM contents back out.
module ext_mem_loader
   import ext_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_len,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_data,
   output logic [31:0] addr_ext,
   output logic [31:0] wdata_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   input  logic [31:0] rdata_ext,
   output logic [31:0] addr_ext_2,
   output logic [31:0] wdata_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   input  logic [31:0] rdata_ext_2,
   output logic        cpu_enable,
   output logic        busy,
   output logic        done,
   output logic        err
);

   state_t      r_state;
   op_t         r_op;
   logic [15:0] r_len;
   logic [15:0] r_cnt;
   logic        r_cmd_ready;
   logic        r_s_ready;
   logic        r_cpu_en;
   logic        r_done;
   logic        r_err;

   logic        w_bad;
   logic        w_beat;
   logic        w_last;
   logic        w_wen_i;
   logic        w_wen_d;
   logic        w_ren_d;
   logic [31:0] w_addr;
   logic        w_unused;

   assign w_beat  = s_valid && r_s_ready;
   assign w_last  = (r_cnt + 16'd1) == r_len;
   assign w_wen_i = w_beat && (r_op == OP_LOAD_IMEM);
   assign w_wen_d = w_beat && (r_op == OP_LOAD_DMEM);
   assign w_addr  = word_addr(r_cnt);

   // Oversized transfers and an unbuilt dump path are rejected up front.
   always_comb begin
      w_bad = 1'b0;
      case (op_t'(cmd_op))
         OP_LOAD_IMEM: w_bad = 32'(cmd_len) > IMEM_DEPTH;
         OP_LOAD_DMEM: w_bad = 32'(cmd_len) > DMEM_DEPTH;
`ifdef LOADER_DUMP_EN
         OP_DUMP_DMEM: w_bad = 32'(cmd_len) > DMEM_DEPTH;
`else
         OP_DUMP_DMEM: w_bad = 1'b1;
`endif
         default:      w_bad = 1'b0;
      endcase
   end

`ifdef LOADER_DUMP_EN
   logic w_load;
   assign w_load  = (r_state == ST_DUMP_WAIT);
   assign w_ren_d = (r_state == ST_DUMP_RD);
   assign w_unused = ^rdata_ext;

   ext_loader_out_reg u_out_reg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_data  (rdata_ext_2),
      .i_ready (m_ready),
      .o_valid (m_valid),
      .o_data  (m_data)
   );
`else
   assign w_ren_d  = 1'b0;
   assign m_valid  = 1'b0;
   assign m_data   = '0;
   assign w_unused = ^{rdata_ext, rdata_ext_2, m_ready};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_LOAD_IMEM;
         r_len       <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b0;
         r_s_ready   <= 1'b0;
         r_cpu_en    <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_op        <= op_t'(cmd_op);
                  r_len       <= cmd_len;
                  r_cnt       <= '0;
                  if (w_bad || cmd_len == 16'd0) begin
                     r_state <= ST_FINISH;
                     r_done  <= 1'b1;
                     r_err   <= w_bad;
                  end else begin
                     case (op_t'(cmd_op))
                        OP_RUN: begin
                           r_state  <= ST_RUN;
                           r_cpu_en <= 1'b1;
                        end
`ifdef LOADER_DUMP_EN
                        OP_DUMP_DMEM: r_state <= ST_DUMP_RD;
`endif
                        default: begin
                           r_state   <= ST_LOAD;
                           r_s_ready <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            ST_LOAD: begin
               if (w_beat) begin
                  r_cnt <= r_cnt + 16'd1;
                  if (w_last) begin
                     r_s_ready <= 1'b0;
                     r_state   <= ST_FINISH;
                     r_done    <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt + 16'd1;
               if (w_last) begin
                  r_cpu_en <= 1'b0;
                  r_state  <= ST_FINISH;
                  r_done   <= 1'b1;
               end
            end
`ifdef LOADER_DUMP_EN
            ST_DUMP_RD:   r_state <= ST_DUMP_WAIT;
            ST_DUMP_WAIT: r_state <= ST_DUMP_OUT;
            ST_DUMP_OUT: begin
               if (m_valid && m_ready) begin
                  r_cnt <= r_cnt + 16'd1;
                  if (w_last) begin
                     r_state <= ST_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_DUMP_RD;
                  end
               end
            end
`endif
            ST_FINISH: begin
               r_done      <= 1'b0;
               r_err       <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign s_ready     = r_s_ready;
   assign cpu_enable  = r_cpu_en;
   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign err         = r_err;

   assign wen_ext     = w_wen_i;
   assign ren_ext     = 1'b0;
   assign addr_ext    = w_wen_i ? w_addr : '0;
   assign wdata_ext   = w_wen_i ? s_data : '0;

   assign wen_ext_2   = w_wen_d;
   assign ren_ext_2   = w_ren_d;
   assign addr_ext_2  = (w_wen_d || w_ren_d) ? w_addr : '0;
   assign wdata_ext_2 = w_wen_d ? s_data : '0;

endmodule

// File: tb/tb_ext_mem_loader.sv
// tb_ext_mem_loader: directed bench for ext_mem_loader; dump expectations
// follow LOADER_DUMP_EN.
module tb_ext_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_len;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [31:0] addr_ext, wdata_ext, rdata_ext;
   logic        wen_ext, ren_ext;
   logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
   logic        wen_ext_2, ren_ext_2;
   logic        cpu_enable, busy, done, err;

   int checks = 0;
   int failures = 0;

   logic [31:0] imem [0:511];
   logic [31:0] dmem [0:1023];
   int   n_wen_i = 0, n_wen_d = 0, n_cpu = 0, n_cpu_rise = 0;
   int   n_done = 0, n_bad = 0, n_mvalid = 0;
   logic last_err = 1'b0;
   logic prev_cpu = 1'b0;

   always #5 clk = ~clk;

   ext_mem_loader dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_len(cmd_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .addr_ext(addr_ext), .wdata_ext(wdata_ext),
      .wen_ext(wen_ext), .ren_ext(ren_ext), .rdata_ext(rdata_ext),
      .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2),
      .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .rdata_ext_2(rdata_ext_2),
      .cpu_enable(cpu_enable), .busy(busy), .done(done), .err(err)
   );

   // Memory models plus event counters watched by the tests.
   always @(posedge clk) begin
      rdata_ext   <= ren_ext ? imem[addr_ext[10:2]] : 32'h0;
      rdata_ext_2 <= ren_ext_2 ? dmem[addr_ext_2[11:2]] : 32'h0;
      if (wen_ext) begin
         n_wen_i++;
         imem[addr_ext[10:2]] = wdata_ext;
      end
      if (wen_ext_2) begin
         n_wen_d++;
         dmem[addr_ext_2[11:2]] = wdata_ext_2;
      end
      if (cpu_enable) n_cpu++;
      if (cpu_enable && !prev_cpu) n_cpu_rise++;
      prev_cpu = cpu_enable;
      if (cpu_enable && (wen_ext | ren_ext | wen_ext_2 | ren_ext_2)) n_bad++;
      if ((wen_ext | ren_ext) && (wen_ext_2 | ren_ext_2)) n_bad++;
      if (m_valid) n_mvalid++;
      if (done) begin
         n_done++;
         last_err = err;
      end
   end

   task automatic send_cmd(input logic [1:0] op, input logic [15:0] len);
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) ok = 1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int  base = n_done;
      bit  ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (n_done != base) ok = 1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_done: no done within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      logic [10:0] flags;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      flags = {cmd_ready, s_ready, m_valid, wen_ext, ren_ext, wen_ext_2,
               ren_ext_2, cpu_enable, busy, done, err};
      checks++;
      if (flags !== 11'h0) begin
         failures++;
         $display("FAIL reset_flags: got %b required 0", flags);
      end
      checks++;
      if ({addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, m_data} !== 160'h0)
      begin
         failures++;
         $display("FAIL reset_buses: m_data=%h addr_ext=%h required 0",
                  m_data, addr_ext);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: cmd_ready=%b busy=%b required 1/0",
                  cmd_ready, busy);
      end
   endtask

   task automatic test_load_imem();
      logic [31:0] data [3];
      int bi = n_wen_i, bd = n_wen_d;
      data[0] = 32'hA0; data[1] = 32'hA1; data[2] = 32'hA2;
      send_cmd(2'd0, 16'd3);
      for (int k = 0; k < 3; k++) begin
         s_valid = 1'b1;
         s_data  = data[k];
         #1;
         checks++;
         if ({wen_ext, wen_ext_2, addr_ext, wdata_ext}
             !== {1'b1, 1'b0, 32'(4 * k), data[k]}) begin
            failures++;
            $display("FAIL load_imem_beat%0d: wen=%b addr=%h wdata=%h required 1 %h %h",
                     k, wen_ext, addr_ext, wdata_ext, 32'(4 * k), data[k]);
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("FAIL load_imem_done: done=%b err=%b required 1/0", done, err);
      end
      @(negedge clk);
      checks++;
      if (n_wen_i - bi != 3 || n_wen_d != bd || imem[2] !== 32'hA2) begin
         failures++;
         $display("FAIL load_imem_count: imem_wr=%0d dmem_wr=%0d required 3/0",
                  n_wen_i - bi, n_wen_d - bd);
      end
   endtask

   task automatic test_load_dmem_bubble();
      int bi = n_wen_i, bd = n_wen_d;
      send_cmd(2'd1, 16'd2);
      s_valid = 1'b1; s_data = 32'hD0;
      @(negedge clk);
      s_valid = 1'b0; s_data = 32'hDEAD;
      #1;
      checks++;
      if (wen_ext_2 !== 1'b0 || s_ready !== 1'b1) begin
         failures++;
         $display("FAIL load_dmem_bubble: wen2=%b s_ready=%b required 0/1",
                  wen_ext_2, s_ready);
      end
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'hD1;
      #1;
      checks++;
      if (wen_ext_2 !== 1'b1 || addr_ext_2 !== 32'h4) begin
         failures++;
         $display("FAIL load_dmem_beat1: wen2=%b addr2=%h required 1/4",
                  wen_ext_2, addr_ext_2);
      end
      @(negedge clk);
      s_valid = 1'b0;
      wait_done(5, "load_dmem");
      checks++;
      if (n_wen_d - bd != 2 || n_wen_i != bi || last_err !== 1'b0
          || dmem[0] !== 32'hD0 || dmem[1] !== 32'hD1) begin
         failures++;
         $display("FAIL load_dmem_count: dmem_wr=%0d imem_wr=%0d err=%b required 2/0/0",
                  n_wen_d - bd, n_wen_i - bi, last_err);
      end
   endtask

   task automatic test_run();
      int bc = n_cpu, br = n_cpu_rise, bb = n_bad;
      int bi = n_wen_i, bd = n_wen_d;
      send_cmd(2'd2, 16'd5);
      wait_done(20, "run");
      checks++;
      if (n_cpu - bc != 5 || n_cpu_rise - br != 1) begin
         failures++;
         $display("FAIL run_cycles: enable_cycles=%0d bursts=%0d required 5/1",
                  n_cpu - bc, n_cpu_rise - br);
      end
      checks++;
      if (n_bad != bb || n_wen_i != bi || n_wen_d != bd || last_err !== 1'b0)
      begin
         failures++;
         $display("FAIL run_quiet: overlaps=%0d err=%b required 0/0",
                  n_bad - bb, last_err);
      end
   endtask

   task automatic test_dump();
      dmem[0] = 32'h11;
      dmem[1] = 32'h22;
      m_ready = 1'b0;
`ifdef LOADER_DUMP_EN
      begin
         logic [31:0] exp [2];
         exp[0] = 32'h11; exp[1] = 32'h22;
         send_cmd(2'd3, 16'd2);
         for (int w = 0; w < 2; w++) begin
            int  n = 0;
            bit  seen = 0;
            while (n < 10 && !seen) begin
               if (m_valid === 1'b1) seen = 1;
               else begin @(negedge clk); n++; end
            end
            checks++;
            if (!seen) begin
               failures++;
               $display("FAIL dump_valid%0d: m_valid=%b required 1", w, m_valid);
            end
            for (int c = 0; c < 3; c++) begin
               checks++;
               if (m_valid !== 1'b1 || m_data !== exp[w]) begin
                  failures++;
                  $display("FAIL dump_hold%0d_%0d: valid=%b data=%h required 1 %h",
                           w, c, m_valid, m_data, exp[w]);
               end
               @(negedge clk);
            end
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
         end
         wait_done(10, "dump");
         checks++;
         if (last_err !== 1'b0) begin
            failures++;
            $display("FAIL dump_err: err=%b required 0", last_err);
         end
      end
`else
      begin
         int bm = n_mvalid;
         send_cmd(2'd3, 16'd2);
         wait_done(3, "dump_illegal");
         checks++;
         if (last_err !== 1'b1 || n_mvalid != bm) begin
            failures++;
            $display("FAIL dump_illegal: err=%b m_valid_cycles=%0d required 1/0",
                     last_err, n_mvalid - bm);
         end
      end
`endif
   endtask

   task automatic test_bounds();
      int bi = n_wen_i, bd = n_wen_d;
      send_cmd(2'd0, 16'd513);
      wait_done(5, "oversize");
      checks++;
      if (last_err !== 1'b1 || n_wen_i != bi) begin
         failures++;
         $display("FAIL oversize: err=%b imem_wr=%0d required 1/0",
                  last_err, n_wen_i - bi);
      end
      send_cmd(2'd1, 16'd0);
      wait_done(5, "zero_len");
      checks++;
      if (last_err !== 1'b0 || n_wen_d != bd) begin
         failures++;
         $display("FAIL zero_len: err=%b dmem_wr=%0d required 0/0",
                  last_err, n_wen_d - bd);
      end
   endtask

   task automatic test_reset_mid_load();
      int bi = n_wen_i, bdn;
      send_cmd(2'd0, 16'd4);
      s_valid = 1'b1; s_data = 32'hB0;
      @(negedge clk);
      s_valid = 1'b0;
      bdn = n_done;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_state: busy=%b done=%b s_ready=%b required 0",
                  busy, done, s_ready);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_ready: cmd_ready=%b required 1", cmd_ready);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (n_done != bdn || n_wen_i - bi != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_quiet: done_pulses=%0d imem_wr=%0d required 0/1",
                  n_done - bdn, n_wen_i - bi);
      end
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 16'd0;
      s_valid = 1'b0; s_data = 32'h0; m_ready = 1'b0;
      for (int i = 0; i < 512; i++) imem[i] = 32'h0;
      for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;
      test_reset();
      test_load_imem();
      test_load_dmem_bubble();
      test_run();
      test_dump();
      test_bounds();
      test_reset_mid_load();
      checks++;
      if (n_bad != 0) begin
         failures++;
         $display("FAIL enable_overlap: count=%0d required 0", n_bad);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ext_mem_loader.md
EXT_MEM_LOADER -- requirements
Module: ext_mem_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 512, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_DEPTH, default 1024, meaning data-memory depth in 32-bit words.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid/cmd_ready  in/out  1  command handshake.
- cmd_op  in  2  command: 0 LOAD_IMEM, 1 LOAD_DMEM, 2 RUN, 3 DUMP_DMEM.
- cmd_len  in  16  word count for LOAD/DUMP; cycle count for RUN.
- s_valid/s_ready  in/out  1  load-stream handshake.
- s_data  in  32  load-stream word.
- m_valid/m_ready  out/in  1  dump-stream handshake.
- m_data  out  32  dump-stream word.
- addr_ext, wdata_ext  out  32  IMEM external address and write data.
- wen_ext, ren_ext  out  1  IMEM external write and read enables.
- rdata_ext  in  32  IMEM external read data.
- addr_ext_2, wdata_ext_2  out  32  DMEM external address and write data.
- wen_ext_2, ren_ext_2  out  1  DMEM external write and read enables.
- rdata_ext_2  in  32  DMEM external read data.
- cpu_enable  out  1  drives the CPU enable.
- busy  out  1  a command is executing.
- done  out  1  one-cycle completion pulse.
- err  out  1  completion status, valid with done.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, FINISH.
REQ-005 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid&&cmd_ready and captured into internal registers.
REQ-006 SHALL, on acceptance, go to FINISH with err=1 and no memory access when a LOAD/DUMP cmd_len exceeds the target depth.
REQ-007 SHALL, on acceptance, go to FINISH with err=0 and no memory access or enable when cmd_len==0.
REQ-008 SHALL, in LOAD, assert s_ready, and for each s_valid&&s_ready beat drive a one-cycle write (wen=1, wdata=s_data) to the selected memory in the same cycle.
REQ-009 SHALL use byte addresses 0,4,8,… for word k at address 4k.
REQ-010 SHALL leave LOAD for FINISH after cmd_len beats.
REQ-011 SHALL, in RUN, hold cpu_enable=1 for exactly cmd_len consecutive cycles, then go to FINISH.
REQ-012 SHALL hold cpu_enable=0 in every other state.
REQ-013 SHALL run DUMP_DMEM as follows:
- DUMP_RD pulses ren_ext_2 at address 4k.
- DUMP_WAIT captures rdata_ext_2 one cycle later into the m_data register.
- DUMP_OUT holds m_valid=1 with m_data stable until m_ready.
- After the handshake it goes to DUMP_RD for word k+1, or to FINISH after cmd_len words.
REQ-014 SHALL never assert any ext enable while cpu_enable=1, and never assert IMEM and DMEM enables together.
REQ-015 SHALL make FINISH last one cycle with done=1, then return to IDLE.
REQ-016 SHALL assert busy in every state except IDLE.
REQ-017 SHALL drive idle ext outputs to 0.
REQ-018 SHALL tolerate s_valid stalls (bubbles) and m_ready backpressure of any length without losing or duplicating words.
REQ-019 SHALL ignore s_valid outside LOAD (s_ready=0).

Reset
REQ-020 SHALL, with rst high at a clock edge, enter IDLE and abort any in-flight command with no done pulse.
REQ-021 SHALL, on reset, clear every output to 0 except cmd_ready, which goes to 1 on the first cycle after rst deasserts.
REQ-022 SHALL clear the counters and the m_data register to 0 on reset.

Configuration
REQ-023 SHALL, with LOADER_DUMP_EN defined, implement DUMP_DMEM as specified.
REQ-024 SHALL, without LOADER_DUMP_EN, treat op 3 as illegal: go to FINISH with err=1, tie m_valid and ren_ext_2 to 0, and omit the dump states and register.

Structure
REQ-025 SHALL take the op encoding, state enum and default depth constants from shared package ext_loader_pkg.
REQ-026 SHALL place the m_valid/m_data holding register with valid/ready handshake in sub-module ext_loader_out_reg.

Verification
REQ-027 Bench SHALL cover LOAD_IMEM len=3 with data A0,A1,A2:
- Stimulus: s_valid held high.
- Required: writes at 0,4,8 on three consecutive cycles, then done=1, err=0.
REQ-028 Bench SHALL cover LOAD_DMEM len=2 with one idle cycle between beats:
- Required: exactly two DMEM writes, no IMEM writes, then done.
REQ-029 Bench SHALL cover RUN len=5:
- Required: cpu_enable high exactly 5 cycles, all ext enables 0 throughout, then done.
REQ-030 Bench SHALL cover DUMP_DMEM len=2 of preloaded 11,22 with m_ready low for 3 cycles:
- Required: m_data=11 held stable, then 22, then done.
- Without LOADER_DUMP_EN: immediate done with err=1.
REQ-031 Bench SHALL cover LOAD_IMEM len=513:
- Required: done with err=1 and no wen_ext.
- LOAD_DMEM len=0: done with err=0 and no write.
REQ-032 Bench SHALL cover rst asserted mid-LOAD after 1 of 4 beats:
- Required: IDLE, no done pulse, cmd_ready=1 the cycle after rst drops.
